// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// op_bad() flags illegal width codes and misaligned addresses before any bus access.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   // funct3[1:0] encodes the access size for every legal load and store code.
   function automatic logic op_bad(input logic       is_load,
                                   input logic [2:0] f3,
                                   input logic [1:0] a);
      logic illegal;
      logic mis;
      if (is_load)
         illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      else
         illegal = (f3 > F3_SW);
      mis = ((f3[1:0] == 2'b10) && (a != 2'b00)) ||
            ((f3[1:0] == 2'b01) && a[0]);
      return illegal || mis;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the addressed byte/half out of the bus word
// and sign- or zero-extends it according to the load width code.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
      half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
      case (funct3_i)
         F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
         F3_LH:   data_o = {{16{half_v[15]}}, half_v};
         F3_LBU:  data_o = {24'h000000, byte_v};
         F3_LHU:  data_o = {16'h0000, half_v};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one bus transaction per memory instruction, with lane
// steering, load extension, misalignment/illegal-code rejection and per-phase timeout.
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        is_load_i,
   input  logic        is_store_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   output logic        stall_o,
   output logic        done_o,
   output logic        fault_o,
   output logic [31:0] load_data_o
);

   localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          is_load_q;
   logic [2:0]    f3_q;
   logic [1:0]    alo_q;
   logic          req_q;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic          tfault_q;
   logic [31:0]   ldata_q;

   logic          mem_op;
   logic          bad;
   logic          accept;
   logic          reject;
   logic          timeout_hit;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wdata;
   logic [31:0]   ext_data;

   assign mem_op      = valid_i & (is_load_i | is_store_i);
   assign bad         = op_bad(is_load_i, funct3_i, addr_i[1:0]);
   assign accept      = (state_q == IDLE) & mem_op & ~bad;
   assign reject      = (state_q == IDLE) & mem_op & bad;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TO_LAST));

   always_comb begin
      lane_be    = 4'hF;
      lane_wdata = 32'h0;
      case (funct3_i[1:0])
         2'b00:   lane_be = 4'b0001 << addr_i[1:0];
         2'b01:   lane_be = 4'b0011 << addr_i[1:0];
         default: lane_be = 4'hF;
      endcase
      if (!is_load_i) begin
         case (funct3_i[1:0])
            2'b00:   lane_wdata = {4{wdata_i[7:0]}};
            2'b01:   lane_wdata = {2{wdata_i[15:0]}};
            default: lane_wdata = wdata_i;
         endcase
      end
   end

   lsu_load_align u_align (
      .rdata_i   (bus_rdata_i),
      .addr_lo_i (alo_q),
      .funct3_i  (f3_q),
      .data_o    (ext_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         is_load_q <= 1'b0;
         f3_q      <= 3'd0;
         alo_q     <= 2'd0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 32'h0;
         be_q      <= 4'h0;
         wdata_q   <= 32'h0;
         tfault_q  <= 1'b0;
         ldata_q   <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               tfault_q <= 1'b0;
               if (accept) begin
                  state_q   <= REQ;
                  cnt_q     <= '0;
                  is_load_q <= is_load_i;
                  f3_q      <= funct3_i;
                  alo_q     <= addr_i[1:0];
                  req_q     <= 1'b1;
                  we_q      <= ~is_load_i;
                  addr_q    <= {addr_i[31:2], 2'b00};
                  be_q      <= lane_be;
                  wdata_q   <= lane_wdata;
               end
            end
            REQ: begin
               // Grant wins over a timeout landing in the same cycle.
               if (bus_gnt_i || timeout_hit) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  addr_q  <= 32'h0;
                  be_q    <= 4'h0;
                  wdata_q <= 32'h0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
               if (bus_gnt_i) begin
                  state_q <= is_load_q ? RESP : DONE;
               end else if (timeout_hit) begin
                  state_q  <= DONE;
                  tfault_q <= 1'b1;
                  if (is_load_q)
                     ldata_q <= 32'h0;
               end
            end
            RESP: begin
               if (bus_rvalid_i) begin
                  ldata_q <= ext_data;
                  state_q <= DONE;
               end else if (timeout_hit) begin
                  ldata_q  <= 32'h0;
                  tfault_q <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               tfault_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus_req_o   = req_q;
   assign bus_we_o    = we_q;
   assign bus_addr_o  = addr_q;
   assign bus_be_o    = be_q;
   assign bus_wdata_o = wdata_q;
   assign stall_o     = (state_q == REQ) | (state_q == RESP) | accept;
   assign done_o      = (state_q == DONE);
   assign fault_o     = reject | ((state_q == DONE) & tfault_q);
   assign load_data_o = ldata_q;

endmodule
